// File: rtl/instr_register_param.sv
// rtl/instr_register_param.sv - parametrised instruction register, addressed or FIFO access
// Stores {opcode, operand_a, operand_b, result, err} per entry; the result is computed at write time.
module instr_register_param #(
  parameter int  OP_WIDTH = 32,
  parameter int  DEPTH    = 32,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         fifo_mode,
  input  logic                         load_en,
  input  logic [3:0]                   opcode,
  input  logic signed [OP_WIDTH-1:0]   operand_a,
  input  logic signed [OP_WIDTH-1:0]   operand_b,
  input  logic [AW-1:0]                write_pointer,
  input  logic                         rd_en,
  input  logic [AW-1:0]                read_pointer,
  output logic [3:0]                   rd_opcode,
  output logic signed [OP_WIDTH-1:0]   rd_op_a,
  output logic signed [OP_WIDTH-1:0]   rd_op_b,
  output logic signed [2*OP_WIDTH-1:0] rd_result,
  output logic                         rd_valid,
  output logic                         rd_err,
  output logic                         full,
  output logic                         empty,
  output logic [AW:0]                  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int          RW       = 2 * OP_WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;

  logic [3:0]                 op_mem_q  [DEPTH];
  logic signed [OP_WIDTH-1:0] a_mem_q   [DEPTH];
  logic signed [OP_WIDTH-1:0] b_mem_q   [DEPTH];
  logic signed [RW-1:0]       res_mem_q [DEPTH];
  logic [DEPTH-1:0]           err_mem_q;

  logic                 mode_q;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic [3:0]                 rd_opcode_q;
  logic signed [OP_WIDTH-1:0] rd_op_a_q, rd_op_b_q;
  logic signed [RW-1:0]       rd_result_q;
  logic                       rd_valid_q, rd_err_q;

  logic signed [RW-1:0] a_ext, b_ext, result_d;
  logic                 err_d;

  // Divide in the double-width domain so MIN/-1 yields the exact quotient.
  assign a_ext = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
  assign b_ext = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};

  always_comb begin
    result_d = '0;
    err_d    = 1'b0;
    case (opcode)
      OP_PASSA: result_d = a_ext;
      OP_PASSB: result_d = b_ext;
      OP_ADD:   result_d = a_ext + b_ext;
      OP_SUB:   result_d = a_ext - b_ext;
      OP_MULT:  result_d = a_ext * b_ext;
      OP_DIV: begin
        if (operand_b == '0) err_d = 1'b1;
        else                 result_d = a_ext / b_ext;
      end
      OP_MOD: begin
        if (operand_b == '0) err_d = 1'b1;
        else                 result_d = a_ext % b_ext;
      end
      default:  result_d = '0;
    endcase
  end

  logic          mode_change, pop_ok, push_ok, do_write, do_read;
  logic [AW-1:0] waddr, raddr;

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign mode_change = (fifo_mode != mode_q);
  assign pop_ok      = fifo_mode & rd_en & ~empty;
  assign push_ok     = fifo_mode & load_en & (~full | pop_ok);
  assign do_write    = ~mode_change & (fifo_mode ? push_ok : load_en);
  assign do_read     = ~mode_change & (fifo_mode ? pop_ok : rd_en);
  assign waddr       = fifo_mode ? wr_ptr_q : write_pointer;
  assign raddr       = fifo_mode ? rd_ptr_q : read_pointer;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (mode_change) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (fifo_mode) begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
      if (load_en && !push_ok) overflow_d  = 1'b1;
      if (rd_en && !pop_ok)    underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_mem_q[i]  <= '0;
        a_mem_q[i]   <= '0;
        b_mem_q[i]   <= '0;
        res_mem_q[i] <= '0;
      end
      err_mem_q <= '0;
    end else if (do_write) begin
      op_mem_q[waddr]  <= opcode;
      a_mem_q[waddr]   <= operand_a;
      b_mem_q[waddr]   <= operand_b;
      res_mem_q[waddr] <= result_d;
      err_mem_q[waddr] <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_opcode_q <= '0;
      rd_op_a_q   <= '0;
      rd_op_b_q   <= '0;
      rd_result_q <= '0;
      rd_err_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      mode_q      <= fifo_mode;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= do_read;
      // Read data holds its last value between accepted reads.
      if (do_read) begin
        rd_opcode_q <= op_mem_q[raddr];
        rd_op_a_q   <= a_mem_q[raddr];
        rd_op_b_q   <= b_mem_q[raddr];
        rd_result_q <= res_mem_q[raddr];
        rd_err_q    <= err_mem_q[raddr];
      end
    end
  end

  assign rd_opcode = rd_opcode_q;
  assign rd_op_a   = rd_op_a_q;
  assign rd_op_b   = rd_op_b_q;
  assign rd_result = rd_result_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_instr_register_param.sv
// tb/tb_instr_register_param.sv - self-checking bench for instr_register_param
// Drives a DEPTH=32 and a DEPTH=4 instance with the same stimulus and checks both against a reference model.
module tb_instr_register_param;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic fifo_mode, load_en, rd_en;
  logic [3:0] opcode;
  logic signed [31:0] operand_a, operand_b;
  logic [4:0] wp, rp;

  always #5 clk = ~clk;

  logic [3:0] d32_rd_opcode, d4_rd_opcode;
  logic signed [31:0] d32_rd_op_a, d32_rd_op_b, d4_rd_op_a, d4_rd_op_b;
  logic signed [63:0] d32_rd_result, d4_rd_result;
  logic d32_rd_valid, d32_rd_err, d32_full, d32_empty, d32_overflow, d32_underflow;
  logic d4_rd_valid, d4_rd_err, d4_full, d4_empty, d4_overflow, d4_underflow;
  logic [5:0] d32_count;
  logic [2:0] d4_count;

  instr_register_param #(.OP_WIDTH(32), .DEPTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .fifo_mode(fifo_mode), .load_en(load_en),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(wp), .rd_en(rd_en), .read_pointer(rp),
    .rd_opcode(d32_rd_opcode), .rd_op_a(d32_rd_op_a), .rd_op_b(d32_rd_op_b),
    .rd_result(d32_rd_result), .rd_valid(d32_rd_valid), .rd_err(d32_rd_err),
    .full(d32_full), .empty(d32_empty), .count(d32_count),
    .overflow(d32_overflow), .underflow(d32_underflow)
  );

  instr_register_param #(.OP_WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .fifo_mode(fifo_mode), .load_en(load_en),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(wp[1:0]), .rd_en(rd_en), .read_pointer(rp[1:0]),
    .rd_opcode(d4_rd_opcode), .rd_op_a(d4_rd_op_a), .rd_op_b(d4_rd_op_b),
    .rd_result(d4_rd_result), .rd_valid(d4_rd_valid), .rd_err(d4_rd_err),
    .full(d4_full), .empty(d4_empty), .count(d4_count),
    .overflow(d4_overflow), .underflow(d4_underflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 mirrors the DEPTH=32 instance, index 1 the DEPTH=4 one.
  int         dep [2];
  logic [3:0] m_op  [2][32];
  int         m_a   [2][32];
  int         m_b   [2][32];
  longint     m_res [2][32];
  bit         m_err [2][32];
  int         m_wr [2], m_rd [2], m_cnt [2];
  bit         m_mode [2], m_ovf [2], m_unf [2], m_valid [2];
  logic [3:0] o_op [2];
  int         o_a [2], o_b [2];
  longint     o_res [2];
  bit         o_err [2];

  function automatic longint calc(input logic [3:0] op, input int a, input int b, output bit err);
    longint la, lb;
    la = a;
    lb = b;
    err = 1'b0;
    calc = 0;
    case (op)
      4'd1: calc = la;
      4'd2: calc = lb;
      4'd3: calc = la + lb;
      4'd4: calc = la - lb;
      4'd5: calc = la * lb;
      4'd6: if (b == 0) err = 1'b1; else calc = la / lb;
      4'd7: if (b == 0) err = 1'b1; else calc = la % lb;
      default: calc = 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) begin
        m_op[d][i] = 0; m_a[d][i] = 0; m_b[d][i] = 0; m_res[d][i] = 0; m_err[d][i] = 0;
      end
      m_wr[d] = 0; m_rd[d] = 0; m_cnt[d] = 0;
      m_mode[d] = 0; m_ovf[d] = 0; m_unf[d] = 0; m_valid[d] = 0;
      o_op[d] = 0; o_a[d] = 0; o_b[d] = 0; o_res[d] = 0; o_err[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int D;
      int wa, ra;
      bit mc, pop_ok, push_ok, do_w, do_r, e;
      longint r;
      D = dep[d];
      m_valid[d] = 0;
      mc = (fifo_mode != m_mode[d]);
      m_mode[d] = fifo_mode;
      r = calc(opcode, operand_a, operand_b, e);
      do_w = 0; do_r = 0; wa = 0; ra = 0;
      if (mc) begin
        m_wr[d] = 0; m_rd[d] = 0; m_cnt[d] = 0;
      end else if (!fifo_mode) begin
        do_w = load_en; do_r = rd_en;
        wa = int'(wp) % D; ra = int'(rp) % D;
      end else begin
        pop_ok  = rd_en && (m_cnt[d] > 0);
        push_ok = load_en && ((m_cnt[d] < D) || pop_ok);
        if (rd_en && !pop_ok)   m_unf[d] = 1;
        if (load_en && !push_ok) m_ovf[d] = 1;
        do_w = push_ok; do_r = pop_ok;
        wa = m_wr[d]; ra = m_rd[d];
        if (push_ok) m_wr[d] = (m_wr[d] + 1) % D;
        if (pop_ok)  m_rd[d] = (m_rd[d] + 1) % D;
        m_cnt[d] = m_cnt[d] + int'(push_ok) - int'(pop_ok);
      end
      if (do_r) begin
        o_op[d] = m_op[d][ra]; o_a[d] = m_a[d][ra]; o_b[d] = m_b[d][ra];
        o_res[d] = m_res[d][ra]; o_err[d] = m_err[d][ra]; m_valid[d] = 1;
      end
      if (do_w) begin
        m_op[d][wa] = opcode; m_a[d][wa] = operand_a; m_b[d][wa] = operand_b;
        m_res[d][wa] = r; m_err[d][wa] = e;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input int d, input logic [3:0] op, input logic signed [31:0] a,
                         input logic signed [31:0] b, input logic signed [63:0] res,
                         input logic v, input logic e, input logic fu, input logic em,
                         input logic [5:0] cnt, input logic ov, input logic un);
    string p;
    p = $sformatf("u%0d.", dep[d]);
    chk({p, "rd_valid"},  64'(v),   64'(m_valid[d]));
    chk({p, "rd_opcode"}, 64'(op),  64'(o_op[d]));
    chk({p, "rd_op_a"},   a,        o_a[d]);
    chk({p, "rd_op_b"},   b,        o_b[d]);
    chk({p, "rd_result"}, res,      o_res[d]);
    chk({p, "rd_err"},    64'(e),   64'(o_err[d]));
    chk({p, "full"},      64'(fu),  64'(m_cnt[d] == dep[d]));
    chk({p, "empty"},     64'(em),  64'(m_cnt[d] == 0));
    chk({p, "count"},     64'(cnt), 64'(m_cnt[d]));
    chk({p, "overflow"},  64'(ov),  64'(m_ovf[d]));
    chk({p, "underflow"}, 64'(un),  64'(m_unf[d]));
  endtask

  task automatic compare_all();
    chk_dut(0, d32_rd_opcode, d32_rd_op_a, d32_rd_op_b, d32_rd_result, d32_rd_valid, d32_rd_err,
            d32_full, d32_empty, d32_count, d32_overflow, d32_underflow);
    chk_dut(1, d4_rd_opcode, d4_rd_op_a, d4_rd_op_b, d4_rd_result, d4_rd_valid, d4_rd_err,
            d4_full, d4_empty, 6'(d4_count), d4_overflow, d4_underflow);
  endtask

  task automatic drive(input bit fm, input bit le, input logic [3:0] op, input int a, input int b,
                       input int w, input bit re, input int r);
    fifo_mode = fm; load_en = le; opcode = op; operand_a = a; operand_b = b;
    wp = 5'(w); rd_en = re; rp = 5'(r);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  logic [3:0] op_tab [8];
  longint     ex_tab [8];
  int         pops   [4];
  int         raddrs [4];

  initial begin
    dep[0] = 32; dep[1] = 4;
    op_tab = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12};
    ex_tab = '{0, -7, 2, -9, -14, -3, -1, 0};
    pops   = '{11, 12, 13, 200};
    raddrs = '{0, 5, 17, 31};
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset_empty", 64'(d32_empty), 1);
    chk("reset_count", 64'(d32_count), 0);
    reset_n = 1'b1;

    // Addressed write then read of address 7
    drive(0, 1, 4'd3, 5, -3, 7, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    step();
    chk("addr_rd_valid",  64'(d32_rd_valid), 1);
    chk("addr_rd_opcode", 64'(d32_rd_opcode), 3);
    chk("addr_rd_op_a",   d32_rd_op_a, 5);
    chk("addr_rd_op_b",   d32_rd_op_b, -3);
    chk("addr_rd_result", d32_rd_result, 2);
    chk("addr_rd_err",    64'(d32_rd_err), 0);

    for (int i = 0; i < 8; i++) begin
      drive(0, 1, op_tab[i], -7, 2, 8 + i, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 1, 8 + i);
      step();
      chk($sformatf("sweep_op%0d_result", op_tab[i]), d32_rd_result, ex_tab[i]);
      chk($sformatf("sweep_op%0d_err", op_tab[i]), 64'(d32_rd_err), 0);
    end
    drive(0, 1, 4'd6, -7, 0, 20, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 20);
    step();
    chk("div0_result", d32_rd_result, 0);
    chk("div0_err", 64'(d32_rd_err), 1);

    // Random addressed traffic, including same-cycle write/read of one entry
    for (int i = 0; i < 60; i++) begin
      drive(0, 1'($urandom), 4'($urandom),
            int'($urandom),
            ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 200)) - 100,
            int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 31)));
      step();
    end

    // FIFO fill / overflow / wrap on the DEPTH=4 instance
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 4'd1, 10 + i, 0, 0, 0, 0);
      step();
    end
    chk("fifo_full_after4", 64'(d4_full), 1);
    chk("fifo_count_after4", 64'(d4_count), 4);
    drive(1, 1, 4'd1, 100, 0, 0, 0, 0);
    step();
    chk("fifo_overflow", 64'(d4_overflow), 1);
    chk("fifo_count_after_ovf", 64'(d4_count), 4);
    drive(1, 1, 4'd1, 200, 0, 0, 1, 0);
    step();
    chk("fifo_pushpop_valid", 64'(d4_rd_valid), 1);
    chk("fifo_pushpop_count", 64'(d4_count), 4);
    chk("fifo_pushpop_data", d4_rd_op_a, 10);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 0);
      step();
      chk($sformatf("fifo_pop%0d_valid", i), 64'(d4_rd_valid), 1);
      chk($sformatf("fifo_pop%0d_data", i), d4_rd_op_a, pops[i]);
    end
    chk("fifo_empty_after_drain", 64'(d4_empty), 1);

    drive(1, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk("underflow_flag", 64'(d4_underflow), 1);
    chk("underflow_valid", 64'(d4_rd_valid), 0);
    drive(1, 1, 4'd1, 7, 0, 0, 1, 0);
    step();
    chk("empty_pushpop_valid", 64'(d4_rd_valid), 0);
    chk("empty_pushpop_count", 64'(d4_count), 1);

    // Mode toggles clear pointers but keep contents; requests on a toggle edge are ignored
    drive(0, 1, 4'd3, 1, 1, 0, 1, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 1, 4'd1, 300, 0, 0, 0, 0);
    step();
    drive(1, 1, 4'd1, 301, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("toggle_count", 64'(d4_count), 0);
    chk("toggle_empty", 64'(d4_empty), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk("toggle_retained_u4", d4_rd_op_a, 300);
    chk("toggle_retained_u32", d32_rd_op_a, 300);

    // Random FIFO traffic: push-heavy then pop-heavy
    for (int i = 0; i < 80; i++) begin
      drive(1, (i < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            4'($urandom), int'($urandom),
            ($urandom_range(0, 3) == 0) ? 0 : int'($urandom),
            0, (i < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0), 0);
      step();
    end

    // Asynchronous reset between edges with three entries queued
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'd3, 400 + i, 1, 0, 0, 0);
      step();
    end
    chk("pre_reset_count", 64'(d4_count), 3);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_reset_count", 64'(d4_count), 0);
    chk("async_reset_empty", 64'(d4_empty), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, raddrs[i]);
      step();
      chk($sformatf("post_reset_rd%0d_valid", raddrs[i]), 64'(d32_rd_valid), 1);
      chk($sformatf("post_reset_rd%0d_result", raddrs[i]), d32_rd_result, 0);
      chk($sformatf("post_reset_rd%0d_op_a", raddrs[i]), d32_rd_op_a, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
